// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32x32 multiply / 32/32 divide unit with HI/LO registers.
// One iteration per cycle for 32 cycles (CALC), then a single sign-fix cycle
// (SIGN) that writes HI/LO and raises a registered one-cycle done pulse.
// Datapath works on magnitudes; signed ops are corrected in SIGN.
//
// Handshake: start is only looked at while busy=0; a start seen at an edge in
// IDLE launches the operation and busy rises for the next 33 cycles. Any start,
// mthi or mtlo presented while busy=1 is dropped, never queued.
module muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] srca,
  input  logic [31:0] srcb,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wd,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_SIGN = 2'd2
  } state_e;

  // Control state
  state_e      state_q;
  logic [4:0]  cnt_q;
  logic        busy_q;
  logic        done_q;

  // Latched operation description
  logic        div_q;       // 1: divide, 0: multiply
  logic        sign_a_q;    // operand A negative (signed ops only)
  logic        sign_b_q;    // operand B negative (signed ops only)
  logic        divzero_q;   // divide with zero divisor
  logic [31:0] mag_a_q;     // multiplicand magnitude
  logic [31:0] mag_b_q;     // divisor magnitude

  // Working registers: acc_q is the 64-bit product accumulator for multiply;
  // for divide its low half shifts the dividend out and the quotient in.
  logic [63:0] acc_q;
  logic [31:0] rem_q;

  // Architectural result registers
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  // Launch-time operand conditioning
  logic        in_signed;
  logic        in_div;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] abs_a;
  logic [31:0] abs_b;

  // Iteration next values
  logic [32:0] mul_sum;
  logic [32:0] div_part;
  logic [32:0] div_trial;
  logic [63:0] acc_d;
  logic [31:0] rem_d;

  // Sign-correction results
  logic        neg_res;
  logic [63:0] prod_fix;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;
  logic [31:0] res_hi_d;
  logic [31:0] res_lo_d;

  // Operand sign/magnitude extraction for the launching edge.
  always_comb begin
    in_signed = ~op[0];
    in_div    = op[1];
    a_neg     = in_signed & srca[31];
    b_neg     = in_signed & srcb[31];
    abs_a     = a_neg ? (~srca + 32'd1) : srca;
    abs_b     = b_neg ? (~srcb + 32'd1) : srcb;
  end

  // One shift-add or one restoring-divide step, chosen by the latched op.
  always_comb begin
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mag_a_q} : 33'd0);
    div_part  = {rem_q, acc_q[31]};
    div_trial = div_part - {1'b0, mag_b_q};
    acc_d     = acc_q;
    rem_d     = rem_q;
    if (div_q) begin
      if (div_trial[32]) begin
        // Trial went negative: keep the shifted remainder, quotient bit 0.
        rem_d = div_part[31:0];
        acc_d = {32'd0, acc_q[30:0], 1'b0};
      end else begin
        rem_d = div_trial[31:0];
        acc_d = {32'd0, acc_q[30:0], 1'b1};
      end
    end else begin
      acc_d = {mul_sum, acc_q[31:1]};
    end
  end

  // Signed result fix-up. A zero divisor forces an all-ones quotient; the
  // remainder then equals |A| and the dividend-sign fix restores srca exactly.
  always_comb begin
    neg_res  = sign_a_q ^ sign_b_q;
    prod_fix = neg_res ? (~acc_q + 64'd1) : acc_q;
    if (divzero_q) begin
      quot_fix = 32'hFFFF_FFFF;
    end else if (neg_res) begin
      quot_fix = ~acc_q[31:0] + 32'd1;
    end else begin
      quot_fix = acc_q[31:0];
    end
    rem_fix  = sign_a_q ? (~rem_q + 32'd1) : rem_q;
    res_hi_d = div_q ? rem_fix  : prod_fix[63:32];
    res_lo_d = div_q ? quot_fix : prod_fix[31:0];
  end

  // Control FSM with registered busy/done and HI/LO updates.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 5'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      div_q     <= 1'b0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      divzero_q <= 1'b0;
      mag_a_q   <= 32'd0;
      mag_b_q   <= 32'd0;
      acc_q     <= 64'd0;
      rem_q     <= 32'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            // Start wins over a simultaneous move.
            div_q     <= in_div;
            sign_a_q  <= a_neg;
            sign_b_q  <= b_neg;
            divzero_q <= in_div & (srcb == 32'd0);
            mag_a_q   <= abs_a;
            mag_b_q   <= abs_b;
            acc_q     <= in_div ? {32'd0, abs_a} : {32'd0, abs_b};
            rem_q     <= 32'd0;
            cnt_q     <= 5'd0;
            busy_q    <= 1'b1;
            state_q   <= S_CALC;
          end else begin
            if (mthi) hi_q <= wd;
            if (mtlo) lo_q <= wd;
          end
        end
        S_CALC: begin
          acc_q <= acc_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q <= S_SIGN;
          end
        end
        S_SIGN: begin
          hi_q    <= res_hi_d;
          lo_q    <= res_lo_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: reference model of HI/LO/busy/done checked every
// cycle, plus literal checks of the known corner cases.
module tb_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wd;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  muldiv_unit dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .srca  (srca),
    .srcb  (srcb),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .wd    (wd),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference arithmetic straight from the operation definitions.
  function automatic void ref_calc(input logic [1:0] o, input logic [31:0] a,
                                   input logic [31:0] b,
                                   output logic [31:0] rh, output logic [31:0] rl);
    longint      sp;
    logic [63:0] up;
    int          sa;
    int          sb;
    sa = a;
    sb = b;
    rh = 32'd0;
    rl = 32'd0;
    case (o)
      2'b00: begin
        sp = longint'(sa) * longint'(sb);
        {rh, rl} = sp;
      end
      2'b01: begin
        up = {32'd0, a} * {32'd0, b};
        {rh, rl} = up;
      end
      2'b10: begin
        if (b == 32'd0) begin
          rl = 32'hFFFF_FFFF; rh = a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          rl = 32'h8000_0000; rh = 32'd0;
        end else begin
          rl = sa / sb; rh = sa % sb;
        end
      end
      default: begin
        if (b == 32'd0) begin
          rl = 32'hFFFF_FFFF; rh = a;
        end else begin
          rl = a / b; rh = a % b;
        end
      end
    endcase
  endfunction

  // Behavioural model: an operation occupies 33 cycles after its start edge,
  // results appear with done in the cycle after that.
  int          m_left = 0;
  bit          m_ok   = 0;
  logic        m_done;
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [31:0] m_phi;
  logic [31:0] m_plo;

  always @(posedge clk) begin
    if (reset) begin
      m_left = 0; m_done = 1'b0; m_hi = 32'd0; m_lo = 32'd0; m_ok = 1;
    end else if (m_ok) begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_hi = m_phi; m_lo = m_plo; m_done = 1'b1;
        end
      end else if (start) begin
        ref_calc(op, srca, srcb, m_phi, m_plo);
        m_left = 33;
      end else begin
        if (mthi) m_hi = wd;
        if (mtlo) m_lo = wd;
      end
    end
  end

  // Scoreboard compare: every cycle once the model has seen reset.
  always @(negedge clk) begin
    if (m_ok) begin
      chk("busy", {31'd0, busy}, {31'd0, (m_left > 0)});
      chk("done", {31'd0, done}, {31'd0, m_done});
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
    end
  end

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return $urandom_range(0, 100);
      5: return 32'd0 - $urandom_range(1, 100);
      default: return $urandom;
    endcase
  endfunction

  // Driver: launch one op, optionally disturb inputs while busy, wait for done.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit rnd, output logic [31:0] rh, output logic [31:0] rl,
                        output int lat);
    int  start_c;
    bit  seen;
    @(posedge clk); #1;
    reset = 1'b0;
    start = 1'b1; op = o; srca = a; srcb = b;
    if (rnd) begin
      mthi = 1'($urandom_range(0, 1)); mtlo = 1'($urandom_range(0, 1)); wd = $urandom;
    end
    @(posedge clk); #1;
    start_c = cyc - 1;
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    if (rnd) begin
      repeat (28) begin
        @(posedge clk); #1;
        start = 1'($urandom_range(0, 1)); op = 2'($urandom_range(0, 3));
        srca = $urandom; srcb = $urandom;
        mthi = 1'($urandom_range(0, 1)); mtlo = 1'($urandom_range(0, 1)); wd = $urandom;
      end
      start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    end
    seen = 0;
    for (int i = 0; i < 45 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1;
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
    rh  = hi;
    rl  = lo;
    lat = cyc - start_c;
  endtask

  task automatic idle_move();
    @(posedge clk); #1;
    mthi = 1'($urandom_range(0, 1)); mtlo = 1'($urandom_range(0, 1)); wd = $urandom;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
  endtask

  logic [31:0] rh;
  logic [31:0] rl;
  int          lat;

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; srca = 32'd0; srcb = 32'd0;
    mthi = 1'b0; mtlo = 1'b0; wd = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);

    // Start on the first edge after reset drops.
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, rh, rl, lat);
    chk("multu_ff_hi", rh, 32'hFFFF_FFFE);
    chk("multu_ff_lo", rl, 32'h0000_0001);
    chk("multu_ff_lat", lat, 34);

    run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 0, rh, rl, lat);
    chk("mult_neg_hi", rh, 32'hFFFF_FFFF);
    chk("mult_neg_lo", rl, 32'hFFFF_FFEB);

    run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 0, rh, rl, lat);
    chk("div_neg_hi", rh, 32'hFFFF_FFFF);
    chk("div_neg_lo", rl, 32'hFFFF_FFFD);

    run_op(2'b11, 32'h0000_0064, 32'h0000_0000, 0, rh, rl, lat);
    chk("divu_z_hi", rh, 32'h0000_0064);
    chk("divu_z_lo", rl, 32'hFFFF_FFFF);

    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, rh, rl, lat);
    chk("div_ovf_hi", rh, 32'h0000_0000);
    chk("div_ovf_lo", rl, 32'h8000_0000);
    chk("div_ovf_lat", lat, 34);

    run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 0, rh, rl, lat);
    chk("div_z_neg_hi", rh, 32'hFFFF_FFF9);
    chk("div_z_neg_lo", rl, 32'hFFFF_FFFF);

    // Busy/reset rules: start in cycle 0, second start + mthi in cycle 10,
    // reset sampled at the end of cycle 20.
    @(posedge clk); #1;
    start = 1'b1; op = 2'b01; srca = 32'd5; srcb = 32'd6;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    start = 1'b1; op = 2'b11; mthi = 1'b1; wd = 32'h1234_5678;
    @(posedge clk); #1;
    start = 1'b0; mthi = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    mtlo = 1'b1; wd = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    mtlo = 1'b0;
    chk("mtlo_lo", lo, 32'hA5A5_A5A5);
    chk("mtlo_hi", hi, 32'd0);
    @(posedge clk); #1;
    mthi = 1'b1; mtlo = 1'b1; wd = 32'h0BAD_F00D;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
    chk("mtboth_hi", hi, 32'h0BAD_F00D);
    chk("mtboth_lo", lo, 32'h0BAD_F00D);

    // Randomized traffic; model comparison runs every cycle.
    for (int n = 0; n < 30; n++) begin
      run_op(2'($urandom_range(0, 3)), pick_val(), pick_val(), 1, rh, rl, lat);
      if ($urandom_range(0, 1) == 1) idle_move();
    end

    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
